// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: opcodes, ALU op codes, operand selects and bundle sizing for the ALU-control decode stage
package alu_ctrl_pkg;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_SLL   = 5'd2;
    localparam logic [4:0] ALU_SLT   = 5'd3;
    localparam logic [4:0] ALU_SLTU  = 5'd4;
    localparam logic [4:0] ALU_XOR   = 5'd5;
    localparam logic [4:0] ALU_SRL   = 5'd6;
    localparam logic [4:0] ALU_SRA   = 5'd7;
    localparam logic [4:0] ALU_OR    = 5'd8;
    localparam logic [4:0] ALU_AND   = 5'd9;
    localparam logic [4:0] ALU_PASSB = 5'd10;
    localparam logic [4:0] ALU_MUL   = 5'd11;

    localparam logic       SRC_A_RS1  = 1'b0;
    localparam logic       SRC_A_PC   = 1'b1;
    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_IMM  = 2'd1;
    localparam logic [1:0] SRC_B_FOUR = 2'd2;

    // bundle = {alu_op, src_a, src_b, imm, pc, jump, illegal}
    function automatic int bundle_w(int xlen, int op_w);
        return op_w + 2 * xlen + 5;
    endfunction

    // alt selects SUB/SRA in the funct3 slots that share ADD/SRL
    function automatic logic [4:0] f3_op(logic [2:0] f3, logic alt);
        case (f3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction
endpackage

// File: rtl/alu_ctrl_decode_pipe_dec.sv
// alu_ctrl_dec: combinational instruction word to ALU-control fields
module alu_ctrl_dec
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OP_W = 5,
    parameter bit EN_M = 1'b0
) (
    input  logic [31:0]     inst,
    output logic [OP_W-1:0] alu_op,
    output logic            src_a,
    output logic [1:0]      src_b,
    output logic [XLEN-1:0] imm,
    output logic            jump,
    output logic            illegal
);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [XLEN-1:0] imm_i, imm_u, imm_j;
    logic [5:0] shamt, sh_hi;
    logic sh_ok;
    logic unused_bits;
    assign opc = inst[6:0];
    assign f3 = inst[14:12];
    assign f7 = inst[31:25];
    assign imm_i = XLEN'($signed(inst[31:20]));
    assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
    assign shamt = (XLEN == 64) ? inst[25:20] : {1'b0, inst[24:20]};
    // bits above shamt must be zero apart from bit 30, which is only meaningful for right shifts
    assign sh_hi = (XLEN == 64) ? {1'b0, inst[31], inst[29:26]} : {inst[31], inst[29:25]};
    assign sh_ok = (sh_hi == 6'd0) && (!inst[30] || f3 == 3'd5);
    assign unused_bits = ^inst[11:7];
    always_comb begin
        alu_op = OP_W'(ALU_ADD);
        src_a = SRC_A_RS1;
        src_b = SRC_B_RS2;
        imm = '0;
        jump = 1'b0;
        illegal = 1'b0;
        case (opc)
            OP_LUI: begin
                alu_op = OP_W'(ALU_PASSB);
                src_b = SRC_B_IMM;
                imm = imm_u;
            end
            OP_AUIPC: begin
                src_a = SRC_A_PC;
                src_b = SRC_B_IMM;
                imm = imm_u;
            end
            OP_JAL: begin
                src_a = SRC_A_PC;
                src_b = SRC_B_FOUR;
                imm = imm_j;
                jump = 1'b1;
            end
            OP_JALR: begin
                if (f3 == 3'd0) begin
                    src_a = SRC_A_PC;
                    src_b = SRC_B_FOUR;
                    imm = imm_i;
                    jump = 1'b1;
                end else illegal = 1'b1;
            end
            OP_IMM: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    if (sh_ok) begin
                        alu_op = OP_W'(f3_op(f3, inst[30]));
                        src_b = SRC_B_IMM;
                        imm = XLEN'(shamt);
                    end else illegal = 1'b1;
                end else begin
                    alu_op = OP_W'(f3_op(f3, 1'b0));
                    src_b = SRC_B_IMM;
                    imm = imm_i;
                end
            end
            OP_REG: begin
                if (f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5)))
                    alu_op = OP_W'(f3_op(f3, inst[30]));
                else if (f7 == 7'b0000001 && EN_M)
                    alu_op = OP_W'(ALU_MUL + {2'b0, f3});
                else illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/alu_ctrl_decode_pipe.sv
// alu_ctrl_decode_pipe: registered ALU-control decode with output + skid buffer for full-rate backpressure
module alu_ctrl_decode_pipe
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OP_W = 5,
    parameter bit EN_M = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] out_alu_op,
    output logic            out_src_a,
    output logic [1:0]      out_src_b,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_pc,
    output logic            out_jump,
    output logic            out_illegal
);
    localparam int DW = bundle_w(XLEN, OP_W);
    logic [OP_W-1:0] d_op;
    logic d_a, d_jump, d_ill;
    logic [1:0] d_b;
    logic [XLEN-1:0] d_imm;
    logic [DW-1:0] dec, out_q, skid_q;
    logic skid_valid, acc;
    alu_ctrl_dec #(.XLEN(XLEN), .OP_W(OP_W), .EN_M(EN_M)) u_dec (
        .inst(in_inst), .alu_op(d_op), .src_a(d_a), .src_b(d_b),
        .imm(d_imm), .jump(d_jump), .illegal(d_ill)
    );
    assign dec = {d_op, d_a, d_b, d_imm, in_pc, d_jump, d_ill};
    assign in_ready = !skid_valid;
    assign acc = in_valid && in_ready;
    assign {out_alu_op, out_src_a, out_src_b, out_imm, out_pc, out_jump, out_illegal} = out_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
            skid_q <= '0;
            out_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || out_ready) begin
            out_q <= skid_valid ? skid_q : acc ? dec : out_q;
            out_valid <= skid_valid || acc;
            skid_valid <= 1'b0;
        end else if (acc) begin
            skid_q <= dec;
            skid_valid <= 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_ctrl_decode_pipe.sv
// tb_alu_ctrl_decode_pipe: directed checks of decode, handshake, flush and reset
module tb_alu_ctrl_decode_pipe;
    logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [31:0] in_inst = '0, in_pc = '0;
    logic in_ready, out_valid, out_src_a, out_jump, out_illegal;
    logic [4:0] out_alu_op;
    logic [1:0] out_src_b;
    logic [31:0] out_imm, out_pc;
    logic m_in_ready, m_out_valid, m_src_a, m_jump, m_illegal;
    logic [4:0] m_alu_op;
    logic [1:0] m_src_b;
    logic [31:0] m_imm, m_pc;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    alu_ctrl_decode_pipe #(.XLEN(32), .OP_W(5), .EN_M(1'b0)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_op(out_alu_op), .out_src_a(out_src_a), .out_src_b(out_src_b),
        .out_imm(out_imm), .out_pc(out_pc), .out_jump(out_jump), .out_illegal(out_illegal)
    );

    alu_ctrl_decode_pipe #(.XLEN(32), .OP_W(5), .EN_M(1'b1)) dut_m (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(m_out_valid), .out_ready(out_ready),
        .out_alu_op(m_alu_op), .out_src_a(m_src_a), .out_src_b(m_src_b),
        .out_imm(m_imm), .out_pc(m_pc), .out_jump(m_jump), .out_illegal(m_illegal)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] inst, input logic [31:0] pc);
        in_valid = 1'b1;
        in_inst = inst;
        in_pc = pc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic chk_dec(input string tag, input logic [4:0] op, input logic a, input logic [1:0] b,
                           input logic [31:0] imm, input logic j, input logic ill);
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_op"}, out_alu_op, op);
        chk({tag, "_a"}, out_src_a, a);
        chk({tag, "_b"}, out_src_b, b);
        chk({tag, "_imm"}, out_imm, imm);
        chk({tag, "_jump"}, out_jump, j);
        chk({tag, "_ill"}, out_illegal, ill);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_op", out_alu_op, 5'd0);
        chk("rst_imm", out_imm, 32'h0);

        send(32'h00500093, 32'h100);
        chk_dec("addi", 5'd0, 1'b0, 2'd1, 32'h5, 1'b0, 1'b0);
        chk("addi_pc", out_pc, 32'h100);
        send(32'hFFF13093, 32'h104);
        chk_dec("sltiu", 5'd4, 1'b0, 2'd1, 32'hFFFFFFFF, 1'b0, 1'b0);
        send(32'h123450B7, 32'h108);
        chk_dec("lui", 5'd10, 1'b0, 2'd1, 32'h12345000, 1'b0, 1'b0);
        send(32'h40115093, 32'h10C);
        chk_dec("srai", 5'd7, 1'b0, 2'd1, 32'h1, 1'b0, 1'b0);
        send(32'h000080E7, 32'h80000000);
        chk_dec("jalr", 5'd0, 1'b1, 2'd2, 32'h0, 1'b1, 1'b0);
        chk("jalr_pc", out_pc, 32'h80000000);
        send(32'h00001097, 32'h110);
        chk_dec("auipc", 5'd0, 1'b1, 2'd1, 32'h1000, 1'b0, 1'b0);
        send(32'h008000EF, 32'h114);
        chk_dec("jal", 5'd0, 1'b1, 2'd2, 32'h8, 1'b1, 1'b0);
        send(32'h403100B3, 32'h118);
        chk_dec("sub", 5'd1, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
        send(32'h00000000, 32'h11C);
        chk_dec("zero", 5'd0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
        send(32'h40111093, 32'h120);
        chk_dec("slli_bad", 5'd0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
        send(32'h022080B3, 32'h124);
        chk_dec("mul_nom", 5'd0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
        chk("mul_m_op", m_alu_op, 5'd11);
        chk("mul_m_ill", m_illegal, 1'b0);
        chk("mul_m_valid", m_out_valid, 1'b1);
        tick();
        chk("drained", out_valid, 1'b0);

        out_ready = 1'b0;
        send(32'h00100093, 32'h200);
        chk("bp1_imm", out_imm, 32'h1);
        chk("bp1_ready", in_ready, 1'b1);
        send(32'h00200093, 32'h204);
        chk("bp2_ready", in_ready, 1'b0);
        chk("bp2_imm", out_imm, 32'h1);
        in_valid = 1'b1;
        in_inst = 32'h00300093;
        in_pc = 32'h208;
        tick();
        chk("bp3_ready", in_ready, 1'b0);
        chk("bp3_valid", out_valid, 1'b1);
        chk("bp3_imm", out_imm, 32'h1);
        chk("bp3_pc", out_pc, 32'h200);
        out_ready = 1'b1;
        tick();
        chk("rel1_imm", out_imm, 32'h2);
        chk("rel1_pc", out_pc, 32'h204);
        chk("rel1_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("rel2_imm", out_imm, 32'h3);
        chk("rel2_valid", out_valid, 1'b1);
        tick();
        chk("rel3_valid", out_valid, 1'b0);

        out_ready = 1'b0;
        send(32'h00100093, 32'h300);
        send(32'h00200093, 32'h304);
        chk("rfull_ready", in_ready, 1'b0);
        rst = 1'b1;
        #2;
        chk("rst_async_valid", out_valid, 1'b0);
        chk("rst_async_imm", out_imm, 32'h0);
        rst = 1'b0;
        tick();
        chk("rst_rel_ready", in_ready, 1'b1);
        chk("rst_rel_valid", out_valid, 1'b0);

        send(32'h00100093, 32'h400);
        send(32'h00200093, 32'h404);
        chk("ffull_ready", in_ready, 1'b0);
        flush = 1'b1;
        in_valid = 1'b1;
        in_inst = 32'h00300093;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_ready", in_ready, 1'b1);
        tick();
        chk("flush_drop", out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
